// File: rtl/multicycle_ctrl_pkg.sv
// Shared state codes, control-bundle type and small helpers for the
// multi-cycle RV32I sequencer.
package multicycle_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef struct packed {
        logic imem_req;
        logic ir_we;
        logic dmem_req;
        logic dmem_we;
        logic rf_we;
        logic pc_we;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // A load+store encoding is illegal; it is handled as a load.
    function automatic logic store_only(input logic is_load, input logic is_store);
        return is_store & ~is_load;
    endfunction

    function automatic logic mem_access(input logic is_load, input logic is_store);
        return is_load | is_store;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Decoder-flag, memory-handshake and datapath-enable bundle between the
// sequencer (master) and the rest of the core (slave).
interface multicycle_ctrl_if #(
    parameter int RET_W = 32
);
    logic             imem_ready;
    logic             dmem_ready;
    logic             is_load;
    logic             is_store;
    logic             is_writeback;
    logic             is_system;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic             halted;
    logic             fault;
    logic [2:0]       state;
    logic [RET_W-1:0] retired;

    modport master (
        input  imem_ready, dmem_ready, is_load, is_store, is_writeback, is_system,
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
               halted, fault, state, retired
    );

    modport slave (
        output imem_ready, dmem_ready, is_load, is_store, is_writeback, is_system,
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
               halted, fault, state, retired
    );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts MEM cycles spent waiting for dmem_ready; expire flags the last
// cycle the sequencer may still wait before declaring a fault.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic clear,
    input  logic count,
    output logic expire
);
    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;

    assign expire = (cnt_q == TW'(MEM_TIMEOUT - 1));

    // Saturate at expiry so the count never wraps back into the legal range.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (count && !expire) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue RV32I core with
// SYSTEM/timeout halt and a wrapping retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 32
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             fault_q;
    logic             fault_d;
    logic [RET_W-1:0] retired_q;
    ctrl_t            ctl;
    logic             in_mem;
    logic             st_only;
    logic             timer_clear;
    logic             timer_count;
    logic             timer_expire;

    assign in_mem  = (state_q == ST_MEM);
    assign st_only = store_only(bus.is_load, bus.is_store);

    // The timer only runs across consecutive unanswered MEM cycles.
    assign timer_count = !rst && in_mem && !bus.dmem_ready;
    assign timer_clear = rst || !in_mem || bus.dmem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .clear  (timer_clear),
        .count  (timer_count),
        .expire (timer_expire)
    );

    always_comb begin
        ctl     = CTRL_IDLE;
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            ST_FETCH: begin
                ctl.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ctl.ir_we = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = bus.is_system ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (mem_access(bus.is_load, bus.is_store)) begin
                    state_d = ST_MEM;
                end else if (bus.is_writeback) begin
                    state_d = ST_WB;
                end else begin
                    ctl.pc_we = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_MEM: begin
                ctl.dmem_req = 1'b1;
                ctl.dmem_we  = st_only;
                // A ready on the last allowed cycle takes priority over the timeout.
                if (bus.dmem_ready) begin
                    if (st_only) begin
                        ctl.pc_we = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d   = ST_WB;
                    end
                end else if (timer_expire) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end
            end
            ST_WB: begin
                ctl.rf_we = 1'b1;
                ctl.pc_we = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
                fault_d = 1'b1;
            end
        endcase
        // Enables must drop in the very cycle reset is sampled.
        if (rst) begin
            ctl = CTRL_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (ctl.pc_we) begin
                retired_q <= retired_q + RET_W'(1);
            end
        end
    end

    assign bus.imem_req = ctl.imem_req;
    assign bus.ir_we    = ctl.ir_we;
    assign bus.dmem_req = ctl.dmem_req;
    assign bus.dmem_we  = ctl.dmem_we;
    assign bus.rf_we    = ctl.rf_we;
    assign bus.pc_we    = ctl.pc_we;
    assign bus.halted   = !rst && (state_q == ST_HALT);
    assign bus.fault    = !rst && fault_q;
    assign bus.state    = rst ? ST_FETCH : state_q;
    assign bus.retired  = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven and randomized checks of multicycle_ctrl against an
// instruction-level cycle-trace model.
module tb_multicycle_ctrl;

    localparam int MT    = 16;
    localparam int RET_W = 4;

    localparam logic [5:0] E_IREQ = 6'b100000;
    localparam logic [5:0] E_IRWE = 6'b010000;
    localparam logic [5:0] E_DREQ = 6'b001000;
    localparam logic [5:0] E_DWE  = 6'b000100;
    localparam logic [5:0] E_RF   = 6'b000010;
    localparam logic [5:0] E_PC   = 6'b000001;

    localparam int K_ALU = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_BOTH = 4, K_SYS = 5;

    typedef struct {
        logic             rst, irdy, drdy, ld, st, wb, sys;
        logic [2:0]       state;
        logic [5:0]       en;
        logic             halted, fault;
        logic [RET_W-1:0] ret;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_ctrl_if #(.RET_W(RET_W)) bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (MT),
        .RET_W       (RET_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               vec_idx = 0;
    vec_t             q[$];
    vec_t             tbl[7];
    logic [RET_W-1:0] m_ret = '0;
    logic             m_fault = 1'b0;
    logic             c_ld, c_st, c_wb, c_sys;

    function automatic vec_t mk(input logic r, ir, dr, ld, st, wb, sy,
                                input logic [2:0] s, input logic [5:0] en,
                                input logic h, f, input logic [RET_W-1:0] rt);
        vec_t v;
        v.rst = r; v.irdy = ir; v.drdy = dr;
        v.ld = ld; v.st = st; v.wb = wb; v.sys = sy;
        v.state = s; v.en = en; v.halted = h; v.fault = f; v.ret = rt;
        return v;
    endfunction

    function automatic vec_t base(input logic [2:0] s);
        return mk(1'b0, 1'($urandom), 1'($urandom), c_ld, c_st, c_wb, c_sys,
                  s, 6'b0, 1'b0, m_fault, m_ret);
    endfunction

    function automatic vec_t rnd_flags(input vec_t vin);
        vec_t v = vin;
        v.ld = 1'($urandom); v.st = 1'($urandom);
        v.wb = 1'($urandom); v.sys = 1'($urandom);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [10:0] act, exp;
        @(negedge clk);
        rst              = v.rst;
        bus.imem_ready   = v.irdy;
        bus.dmem_ready   = v.drdy;
        bus.is_load      = v.ld;
        bus.is_store     = v.st;
        bus.is_writeback = v.wb;
        bus.is_system    = v.sys;
        #1;
        act = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
               bus.rf_we, bus.pc_we, bus.halted, bus.fault};
        exp = {v.state, v.en, v.halted, v.fault};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s#%0d ctl: got st=%0d en=%b h=%b f=%b, want st=%0d en=%b h=%b f=%b",
                     tag, vec_idx, act[10:8], act[7:2], act[1], act[0],
                     exp[10:8], exp[7:2], exp[1], exp[0]);
        end
        n_cmp++;
        if (bus.retired !== v.ret) begin
            n_bad++;
            $display("FAIL %s#%0d retired: got %0d, want %0d", tag, vec_idx, bus.retired, v.ret);
        end
        vec_idx++;
    endtask

    task automatic run_q(input string tag);
        while (q.size() > 0) apply(q.pop_front(), tag);
    endtask

    task automatic gen_reset();
        vec_t v = rnd_flags(mk(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                               3'd0, 6'b0, 1'b0, 1'b0, '0));
        q.push_back(v);
        m_ret   = '0;
        m_fault = 1'b0;
    endtask

    task automatic gen_halt(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = rnd_flags(base(3'd5));
            v.halted = 1'b1;
            q.push_back(v);
        end
    endtask

    // One instruction as a cycle trace. status: 0 retired, 1 halted, 2 reset mid-MEM.
    task automatic gen_instr(input int kind, input int fw, input int mw,
                             input int abort, output int status);
        vec_t v;
        logic so;
        status = 0;
        c_ld  = (kind == K_LD) || (kind == K_BOTH);
        c_st  = (kind == K_ST) || (kind == K_BOTH);
        c_wb  = (kind == K_ALU) || c_ld;
        c_sys = (kind == K_SYS);
        so    = c_st && !c_ld;
        for (int i = 0; i < fw; i++) begin
            v = rnd_flags(base(3'd0));
            v.irdy = 1'b0; v.en = E_IREQ;
            q.push_back(v);
        end
        v = rnd_flags(base(3'd0));
        v.irdy = 1'b1; v.en = E_IREQ | E_IRWE;
        q.push_back(v);
        q.push_back(base(3'd1));
        if (c_sys) begin
            status = 1;
            return;
        end
        v = base(3'd2);
        if (!c_ld && !c_st && !c_wb) begin
            v.en = E_PC;
            q.push_back(v);
            m_ret = m_ret + RET_W'(1);
            return;
        end
        q.push_back(v);
        if (c_ld || c_st) begin
            for (int i = 0; i < MT; i++) begin
                if (i == abort) begin
                    gen_reset();
                    status = 2;
                    return;
                end
                v = base(3'd3);
                v.en = E_DREQ | (so ? E_DWE : 6'b0);
                if (i == mw) begin
                    v.drdy = 1'b1;
                    if (so) v.en = v.en | E_PC;
                    q.push_back(v);
                    if (so) begin
                        m_ret = m_ret + RET_W'(1);
                        return;
                    end
                    break;
                end
                v.drdy = 1'b0;
                q.push_back(v);
                if (i == MT - 1) begin
                    m_fault = 1'b1;
                    status = 1;
                    return;
                end
            end
        end
        v = base(3'd4);
        v.en = E_RF | E_PC;
        q.push_back(v);
        m_ret = m_ret + RET_W'(1);
    endtask

    initial begin
        int st;
        int k, kind, fw, mw, ab;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        bus.is_load = 1'b0; bus.is_store = 1'b0;
        bus.is_writeback = 1'b0; bus.is_system = 1'b0;

        // ADD with imem_ready on the second FETCH cycle; retired 0 -> 1.
        tbl[0] = mk(1, 1, 1, 0, 0, 0, 0, 3'd0, 6'b0,            0, 0, 4'd0);
        tbl[1] = mk(0, 0, 1, 0, 0, 0, 0, 3'd0, E_IREQ,          0, 0, 4'd0);
        tbl[2] = mk(0, 1, 0, 0, 0, 0, 0, 3'd0, E_IREQ | E_IRWE, 0, 0, 4'd0);
        tbl[3] = mk(0, 1, 1, 0, 0, 1, 0, 3'd1, 6'b0,            0, 0, 4'd0);
        tbl[4] = mk(0, 1, 1, 0, 0, 1, 0, 3'd2, 6'b0,            0, 0, 4'd0);
        tbl[5] = mk(0, 1, 0, 0, 0, 1, 0, 3'd4, E_RF | E_PC,     0, 0, 4'd0);
        tbl[6] = mk(0, 0, 1, 0, 0, 0, 0, 3'd0, E_IREQ,          0, 0, 4'd1);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 7; i++) apply(tbl[i], "add_tbl");
        m_ret = 4'd1;

        gen_instr(K_LD,   0, 2,      -1, st); run_q("lw_3mem");
        gen_instr(K_ST,   0, 0,      -1, st); run_q("sw_0wait");
        gen_instr(K_BR,   1, 0,      -1, st); run_q("beq");
        gen_instr(K_BOTH, 0, 1,      -1, st); run_q("ld_st_both");
        gen_instr(K_LD,   2, MT - 1, -1, st); run_q("lw_last_cycle");
        gen_instr(K_ST,   0, MT - 1, -1, st); run_q("sw_last_cycle");
        gen_instr(K_SYS,  0, 0,      -1, st); gen_halt(4); gen_reset(); run_q("ecall");
        gen_instr(K_ALU,  0, 0,      -1, st); run_q("alu_after_rst");
        gen_instr(K_LD,   0, MT,     -1, st); gen_halt(3); gen_reset(); run_q("timeout");
        gen_instr(K_ST,   0, 5,       2, st); run_q("rst_mid_mem");
        gen_instr(K_LD,   0, 0,      -1, st); run_q("lw_after_abort");

        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 19);
            kind = (k < 4) ? K_ALU : (k < 7) ? K_BR : (k < 11) ? K_LD :
                   (k < 16) ? K_ST : (k < 18) ? K_BOTH : (k == 18) ? K_SYS : K_LD;
            fw = $urandom_range(0, 2);
            k  = $urandom_range(0, 29);
            mw = (k == 0) ? MT : (k == 1) ? MT - 1 : $urandom_range(0, 4);
            ab = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 2) : -1;
            gen_instr(kind, fw, mw, ab, st);
            if (st == 1) begin
                gen_halt($urandom_range(1, 3));
                gen_reset();
            end
            run_q("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
